// File: rtl/console_axi_slave.sv
// -----------------------------------------------------------------------------
// console_axi_slave
//
// AXI responder for the SoC console window on the 128-bit BIU slave fabric.
// Single-beat stores to TXDATA (BASE_ADDR+0x0) push one byte into a TX FIFO.
// The FIFO drains on the char_* valid/ready byte stream. Loads from STATUS
// (BASE_ADDR+0x4) return a console status word. Bursts are accepted and
// answered with SLVERR. One clock domain.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   aw*/w*/b*                AXI write address / data / response channels
//   ar*/r*                   AXI read address / data channels
//   char_valid/ready/data    drained TX byte stream
//
// Build option
//   CONSOLE_SIM_PRINT_EN     when defined, every popped byte is also echoed
//                            with $write (simulation only, not synthesizable)
// -----------------------------------------------------------------------------
module console_axi_slave #(
   parameter logic [39:0] BASE_ADDR  = 40'h0090000000,
   parameter int          FIFO_DEPTH = 16,
   parameter int          ID_W       = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            awvalid,
   output logic            awready,
   input  logic [39:0]     awaddr,
   input  logic [3:0]      awlen,
   input  logic [ID_W-1:0] awid,
   input  logic            wvalid,
   output logic            wready,
   input  logic [127:0]    wdata,
   input  logic [15:0]     wstrb,
   input  logic            wlast,
   output logic            bvalid,
   input  logic            bready,
   output logic [1:0]      bresp,
   output logic [ID_W-1:0] bid,
   input  logic            arvalid,
   output logic            arready,
   input  logic [39:0]     araddr,
   input  logic [3:0]      arlen,
   input  logic [ID_W-1:0] arid,
   output logic            rvalid,
   input  logic            rready,
   output logic [127:0]    rdata,
   output logic [1:0]      rresp,
   output logic            rlast,
   output logic [ID_W-1:0] rid,
   output logic            char_valid,
   input  logic            char_ready,
   output logic [7:0]      char_data
);

   localparam int          PTR_W       = $clog2(FIFO_DEPTH);
   localparam int          LVL_W       = PTR_W + 1;
   localparam logic [1:0]  RESP_OKAY   = 2'b00;
   localparam logic [1:0]  RESP_SLVERR = 2'b10;
   localparam logic [11:0] OFF_TX      = 12'h000;
   localparam logic [11:0] OFF_STATUS  = 12'h004;

   typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} w_state_t;
   typedef enum logic       {R_IDLE = 1'b0, R_DATA = 1'b1} r_state_t;

   w_state_t          w_state_r, w_state_nx_s;
   r_state_t          r_state_r, r_state_nx_s;

   logic [3:0]        aw_len_r, w_cnt_r, ar_len_r, r_cnt_r;
   logic [ID_W-1:0]   aw_id_r, ar_id_r;
   logic              aw_tx_r, ar_status_r;
   logic [1:0]        bresp_r;
   logic [31:0]       snap_r, status_s;

   logic [7:0]        fifo_mem_r [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr_r, rd_ptr_r;
   logic [LVL_W-1:0]  level_r;
   logic              fifo_full_s, fifo_empty_s;

   logic              aw_hs_s, w_hs_s, ar_hs_s, r_hs_s, push_s, pop_s;
   logic              lane_ok_s, w_last_beat_s;
   logic [7:0]        lane_byte_s;
   logic              unused_s;

   // Only one byte per lane is meaningful; the rest of the beat is ignored.
   assign unused_s = ^{wdata, wlast};

   assign fifo_full_s  = (level_r == LVL_W'(FIFO_DEPTH));
   assign fifo_empty_s = (level_r == LVL_W'(0));
   assign status_s     = {16'h0000, 8'(level_r), 6'b000000, fifo_empty_s, fifo_full_s};

   // ---------------- write channel ----------------
   assign awready = (w_state_r == W_IDLE);
   // Backpressure only applies to single-beat TXDATA stores, and uses the
   // registered full flag so a same-cycle pop never opens the gate.
   assign wready  = (w_state_r == W_DATA) &&
                    (((aw_len_r == 4'd0) && aw_tx_r) ? !fifo_full_s : 1'b1);
   assign bvalid  = (w_state_r == W_RESP);
   assign bresp   = bresp_r;
   assign bid     = aw_id_r;

   assign aw_hs_s       = awvalid && awready;
   assign w_hs_s        = wvalid && wready;
   assign w_last_beat_s = (w_cnt_r == aw_len_r);
   assign push_s        = w_hs_s && (aw_len_r == 4'd0) && aw_tx_r && lane_ok_s;

   // Strobe pattern selects which 32-bit lane carries the character.
   always_comb begin
      lane_ok_s   = 1'b1;
      lane_byte_s = 8'h00;
      case (wstrb)
         16'h000f: lane_byte_s = wdata[7:0];
         16'h00f0: lane_byte_s = wdata[39:32];
         16'h0f00: lane_byte_s = wdata[71:64];
         16'hf000: lane_byte_s = wdata[103:96];
         default:  lane_ok_s   = 1'b0;
      endcase
   end

   // Write FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) w_state_r <= W_IDLE;
      else     w_state_r <= w_state_nx_s;
   end

   // Write FSM next-state logic.
   always_comb begin
      w_state_nx_s = w_state_r;
      case (w_state_r)
         W_IDLE: begin
            if (awvalid) w_state_nx_s = W_DATA;
            else         w_state_nx_s = W_IDLE;
         end
         W_DATA: begin
            if (w_hs_s && w_last_beat_s) w_state_nx_s = W_RESP;
            else                         w_state_nx_s = W_DATA;
         end
         W_RESP: begin
            if (bready) w_state_nx_s = W_IDLE;
            else        w_state_nx_s = W_RESP;
         end
         default: w_state_nx_s = W_IDLE;
      endcase
   end

   // Write-side context: latched AW fields, beat counter and pending response.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         aw_len_r <= 4'd0;
         aw_id_r  <= '0;
         aw_tx_r  <= 1'b0;
         w_cnt_r  <= 4'd0;
         bresp_r  <= RESP_OKAY;
      end else begin
         if (aw_hs_s) begin
            aw_len_r <= awlen;
            aw_id_r  <= awid;
            aw_tx_r  <= (awaddr[39:12] == BASE_ADDR[39:12]) && (awaddr[11:0] == OFF_TX);
            w_cnt_r  <= 4'd0;
         end
         if (w_hs_s) begin
            w_cnt_r <= w_cnt_r + 4'd1;
            if ((aw_len_r != 4'd0) || (aw_tx_r && !lane_ok_s)) bresp_r <= RESP_SLVERR;
            else                                               bresp_r <= RESP_OKAY;
         end
      end
   end

   // ---------------- read channel ----------------
   assign arready = (r_state_r == R_IDLE);
   assign rvalid  = (r_state_r == R_DATA);
   assign rlast   = rvalid && (r_cnt_r == ar_len_r);
   assign rresp   = (rvalid && (ar_len_r != 4'd0)) ? RESP_SLVERR : RESP_OKAY;
   assign rdata   = (rvalid && ar_status_r) ? {4{snap_r}} : 128'd0;
   assign rid     = ar_id_r;

   assign ar_hs_s = arvalid && arready;
   assign r_hs_s  = rvalid && rready;

   // Read FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state_r <= R_IDLE;
      else     r_state_r <= r_state_nx_s;
   end

   // Read FSM next-state logic.
   always_comb begin
      r_state_nx_s = r_state_r;
      case (r_state_r)
         R_IDLE: begin
            if (arvalid) r_state_nx_s = R_DATA;
            else         r_state_nx_s = R_IDLE;
         end
         R_DATA: begin
            if (r_hs_s && rlast) r_state_nx_s = R_IDLE;
            else                 r_state_nx_s = R_DATA;
         end
         default: r_state_nx_s = R_IDLE;
      endcase
   end

   // Read-side context; STATUS is snapshotted at the AR handshake so a
   // same-cycle push is not visible in the returned word.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ar_len_r    <= 4'd0;
         ar_id_r     <= '0;
         ar_status_r <= 1'b0;
         r_cnt_r     <= 4'd0;
         snap_r      <= 32'd0;
      end else begin
         if (ar_hs_s) begin
            ar_len_r    <= arlen;
            ar_id_r     <= arid;
            ar_status_r <= (arlen == 4'd0) && (araddr[39:12] == BASE_ADDR[39:12]) &&
                           (araddr[11:0] == OFF_STATUS);
            r_cnt_r     <= 4'd0;
            snap_r      <= status_s;
         end
         if (r_hs_s) r_cnt_r <= r_cnt_r + 4'd1;
      end
   end

   // ---------------- TX FIFO ----------------
   assign char_valid = !fifo_empty_s;
   assign char_data  = char_valid ? fifo_mem_r[rd_ptr_r] : 8'h00;
   assign pop_s      = char_valid && char_ready;

   // FIFO storage; contents need no reset because the level gates visibility.
   always_ff @(posedge clk) begin
      if (push_s) fifo_mem_r[wr_ptr_r] <= lane_byte_s;
   end

   // FIFO pointers and occupancy; pointers wrap naturally at FIFO_DEPTH.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         level_r  <= '0;
      end else begin
         if (push_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
         if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_W'(1);
         case ({push_s, pop_s})
            2'b10:   level_r <= level_r + LVL_W'(1);
            2'b01:   level_r <= level_r - LVL_W'(1);
            default: level_r <= level_r;
         endcase
      end
   end

`ifdef CONSOLE_SIM_PRINT_EN
   // Simulation echo of every drained character.
   always_ff @(posedge clk) begin
      if (!rst && pop_s) $write("%c", char_data);
   end
`else
`endif

endmodule

// File: tb/tb_console_axi_slave.sv
module tb_console_axi_slave;

   localparam logic [39:0] BASE   = 40'h0090000000;
   localparam logic [1:0]  OKAY   = 2'b00;
   localparam logic [1:0]  SLVERR = 2'b10;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         awvalid = 1'b0, awready;
   logic [39:0]  awaddr = 40'd0;
   logic [3:0]   awlen = 4'd0, awid = 4'd0;
   logic         wvalid = 1'b0, wready;
   logic [127:0] wdata = 128'd0;
   logic [15:0]  wstrb = 16'd0;
   logic         wlast = 1'b0;
   logic         bvalid, bready = 1'b0;
   logic [1:0]   bresp;
   logic [3:0]   bid;
   logic         arvalid = 1'b0, arready;
   logic [39:0]  araddr = 40'd0;
   logic [3:0]   arlen = 4'd0, arid = 4'd0;
   logic         rvalid, rready = 1'b0;
   logic [127:0] rdata;
   logic [1:0]   rresp;
   logic         rlast;
   logic [3:0]   rid;
   logic         char_valid, char_ready = 1'b0;
   logic [7:0]   char_data;

   int checks = 0;
   int errors = 0;
   logic [127:0] wd;
   logic [7:0]   exp_byte;

   console_axi_slave dut (
      .clk(clk), .rst(rst),
      .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awlen(awlen), .awid(awid),
      .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
      .bvalid(bvalid), .bready(bready), .bresp(bresp), .bid(bid),
      .arvalid(arvalid), .arready(arready), .araddr(araddr), .arlen(arlen), .arid(arid),
      .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rid(rid),
      .char_valid(char_valid), .char_ready(char_ready), .char_data(char_data)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic do_aw(input logic [39:0] a, input logic [3:0] len, input logic [3:0] id);
      int n = 0;
      awaddr = a; awlen = len; awid = id; awvalid = 1'b1;
      while (awready !== 1'b1 && n < 50) begin tick(); n++; end
      check("aw_ready", 128'(awready), 128'd1);
      tick();
      awvalid = 1'b0;
   endtask

   task automatic do_w(input logic [127:0] d, input logic [15:0] s, input logic l);
      int n = 0;
      wdata = d; wstrb = s; wlast = l; wvalid = 1'b1;
      while (wready !== 1'b1 && n < 50) begin tick(); n++; end
      check("w_ready", 128'(wready), 128'd1);
      tick();
      wvalid = 1'b0;
   endtask

   task automatic wait_b(input string tag, input logic [1:0] resp, input logic [3:0] id);
      int n = 0;
      bready = 1'b1;
      while (bvalid !== 1'b1 && n < 50) begin tick(); n++; end
      check({tag, "_bvalid"}, 128'(bvalid), 128'd1);
      check({tag, "_bresp"}, 128'(bresp), 128'(resp));
      check({tag, "_bid"}, 128'(bid), 128'(id));
      tick();
      bready = 1'b0;
   endtask

   task automatic do_ar(input logic [39:0] a, input logic [3:0] len, input logic [3:0] id);
      int n = 0;
      araddr = a; arlen = len; arid = id; arvalid = 1'b1;
      while (arready !== 1'b1 && n < 50) begin tick(); n++; end
      check("ar_ready", 128'(arready), 128'd1);
      tick();
      arvalid = 1'b0;
   endtask

   task automatic check_r(input string tag, input logic [127:0] d, input logic [1:0] resp,
                          input logic last, input logic [3:0] id);
      int n = 0;
      rready = 1'b1;
      while (rvalid !== 1'b1 && n < 50) begin tick(); n++; end
      check({tag, "_rvalid"}, 128'(rvalid), 128'd1);
      check({tag, "_rdata"}, rdata, d);
      check({tag, "_rresp"}, 128'(rresp), 128'(resp));
      check({tag, "_rlast"}, 128'(rlast), 128'(last));
      check({tag, "_rid"}, 128'(rid), 128'(id));
      tick();
      rready = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // ---- reset state ----
      tick(); tick();
      check("rst_awready", 128'(awready), 128'd1);
      check("rst_arready", 128'(arready), 128'd1);
      check("rst_wready", 128'(wready), 128'd0);
      check("rst_bvalid", 128'(bvalid), 128'd0);
      check("rst_rvalid", 128'(rvalid), 128'd0);
      check("rst_rlast", 128'(rlast), 128'd0);
      check("rst_rdata", rdata, 128'd0);
      check("rst_char_valid", 128'(char_valid), 128'd0);
      check("rst_char_data", 128'(char_data), 128'd0);
      rst = 1'b0;
      tick();

      // ---- 'A' on lane 0, drained immediately ----
      char_ready = 1'b1;
      do_aw(BASE, 4'd0, 4'h3);
      wd = 128'd0; wd[7:0] = 8'h41;
      do_w(wd, 16'h000f, 1'b1);
      check("a_char_valid", 128'(char_valid), 128'd1);
      check("a_char_data", 128'(char_data), 128'h41);
      wait_b("a", OKAY, 4'h3);
      check("a_drained", 128'(char_valid), 128'd0);

      // ---- 'Z' on lane 3 ----
      do_aw(BASE, 4'd0, 4'h5);
      wd = 128'd0; wd[103:96] = 8'h5A;
      do_w(wd, 16'hf000, 1'b1);
      check("z_char_data", 128'(char_data), 128'h5A);
      wait_b("z", OKAY, 4'h5);

      // ---- '~' on lane 2 ----
      do_aw(BASE, 4'd0, 4'h4);
      wd = 128'd0; wd[71:64] = 8'h7E;
      do_w(wd, 16'h0f00, 1'b1);
      check("t_char_data", 128'(char_data), 128'h7E);
      wait_b("t", OKAY, 4'h4);

      // ---- bad strobe: no push, SLVERR ----
      do_aw(BASE, 4'd0, 4'h6);
      wd = 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF;
      do_w(wd, 16'h0ff0, 1'b1);
      check("badstrb_nopush", 128'(char_valid), 128'd0);
      wait_b("badstrb", SLVERR, 4'h6);

      // ---- other offset: ignored, OKAY ----
      do_aw(BASE + 40'h8, 4'd0, 4'h8);
      wd = 128'd0; wd[7:0] = 8'h55;
      do_w(wd, 16'h000f, 1'b1);
      check("off8_nopush", 128'(char_valid), 128'd0);
      wait_b("off8", OKAY, 4'h8);

      // ---- fill FIFO with 16 bytes, 17th is backpressured ----
      char_ready = 1'b0;
      for (int i = 0; i < 16; i++) begin
         do_aw(BASE, 4'd0, i[3:0]);
         wd = 128'd0; wd[7:0] = 8'h30 + i[7:0];
         do_w(wd, 16'h000f, 1'b1);
         wait_b("fill", OKAY, i[3:0]);
      end
      do_aw(BASE, 4'd0, 4'hA);
      wd = 128'd0; wd[7:0] = 8'h99;
      wdata = wd; wstrb = 16'h000f; wlast = 1'b1; wvalid = 1'b1;
      tick(); tick();
      check("full_wready", 128'(wready), 128'd0);
      do_ar(BASE + 40'h4, 4'd0, 4'h1);
      check_r("status_full", {4{32'h00001001}}, OKAY, 1'b1, 4'h1);
      check("full_wready2", 128'(wready), 128'd0);
      check("full_head", 128'(char_data), 128'h30);
      char_ready = 1'b1;
      tick();
      char_ready = 1'b0;
      check("after_pop_wready", 128'(wready), 128'd1);
      check("after_pop_head", 128'(char_data), 128'h31);
      tick();
      wvalid = 1'b0;
      wait_b("w17", OKAY, 4'hA);
      char_ready = 1'b1;
      for (int k = 0; k < 16; k++) begin
         exp_byte = (k < 15) ? (8'h31 + k[7:0]) : 8'h99;
         check("drain_valid", 128'(char_valid), 128'd1);
         check("drain_data", 128'(char_data), 128'(exp_byte));
         tick();
      end
      check("drain_empty", 128'(char_valid), 128'd0);

      // ---- write burst len=3 -> SLVERR, no push ----
      do_aw(BASE, 4'd3, 4'h7);
      wd = 128'd0; wd[7:0] = 8'h61;
      for (int b = 0; b < 4; b++) begin
         if (b == 3) check("burst_no_early_b", 128'(bvalid), 128'd0);
         do_w(wd, 16'h000f, (b == 3));
      end
      check("burst_nopush", 128'(char_valid), 128'd0);
      wait_b("wburst", SLVERR, 4'h7);

      // ---- read burst len=1 -> 2 beats SLVERR ----
      do_ar(BASE, 4'd1, 4'h2);
      check_r("rburst0", 128'd0, SLVERR, 1'b0, 4'h2);
      check_r("rburst1", 128'd0, SLVERR, 1'b1, 4'h2);
      check("rburst_done", 128'(rvalid), 128'd0);

      // ---- reset in W_RESP ----
      char_ready = 1'b0;
      do_aw(BASE, 4'd0, 4'h3);
      wd = 128'd0; wd[7:0] = 8'h41;
      do_w(wd, 16'h000f, 1'b1);
      check("wresp_bvalid", 128'(bvalid), 128'd1);
      check("wresp_fifo", 128'(char_valid), 128'd1);
      rst = 1'b1;
      #1;
      check("rst_async_bvalid", 128'(bvalid), 128'd0);
      check("rst_async_awready", 128'(awready), 128'd1);
      check("rst_async_fifo", 128'(char_valid), 128'd0);
      tick();
      rst = 1'b0;
      tick();
      check("rst_no_b", 128'(bvalid), 128'd0);
      do_ar(BASE + 40'h4, 4'd0, 4'h4);
      check_r("status_empty", {4{32'h00000002}}, OKAY, 1'b1, 4'h4);

      // ---- W and AR handshakes on the same edge ----
      do_aw(BASE, 4'd0, 4'h6);
      wd = 128'd0; wd[7:0] = 8'h42;
      wdata = wd; wstrb = 16'h000f; wlast = 1'b1; wvalid = 1'b1;
      araddr = BASE + 40'h4; arlen = 4'd0; arid = 4'h9; arvalid = 1'b1;
      check("same_wready", 128'(wready), 128'd1);
      check("same_arready", 128'(arready), 128'd1);
      tick();
      wvalid = 1'b0;
      arvalid = 1'b0;
      check("same_char_data", 128'(char_data), 128'h42);
      check_r("same_status", {4{32'h00000002}}, OKAY, 1'b1, 4'h9);
      wait_b("same", OKAY, 4'h6);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
